// File: rtl/bsmul_pkg.sv
// Shared types and address helper for the bit-serial multiply address generator.
package bsmul_pkg;

  localparam int unsigned DEF_BWADDR = 21;
  localparam int unsigned DEF_BWLEN  = 8;
  localparam int unsigned DEF_BWPREC = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Start address of a bit-plane; product and sum wrap modulo 2^DEF_BWADDR.
  function automatic logic [DEF_BWADDR-1:0] plane_addr(
    input logic [DEF_BWADDR-1:0] base,
    input logic [DEF_BWPREC-1:0] off,
    input logic [DEF_BWADDR-1:0] stride
  );
    logic [DEF_BWADDR-1:0] off_x;
    off_x = {{(DEF_BWADDR-DEF_BWPREC){1'b0}}, off};
    return base + off_x * stride;
  endfunction

endpackage

// File: rtl/bsmul_agu.sv
// Bit-serial multiply AGU: walks zigzagu plane pairs and streams LEN word-read beats
// per pair into a single output register with valid/ready handshake.
module bsmul_agu #(
  parameter int unsigned BWADDR = bsmul_pkg::DEF_BWADDR,
  parameter int unsigned BWLEN  = bsmul_pkg::DEF_BWLEN,
  parameter int unsigned BWPREC = bsmul_pkg::DEF_BWPREC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              start_ready,
  input  logic [BWPREC-1:0] pw,
  input  logic [BWPREC-1:0] pd,
  input  logic [BWLEN-1:0]  len,
  input  logic [BWADDR-1:0] wbase,
  input  logic [BWADDR-1:0] dbase,
  input  logic [BWADDR-1:0] wstride,
  input  logic [BWADDR-1:0] dstride,
  output logic              zz_clr,
  output logic              zz_step,
  output logic [BWPREC-1:0] zz_pw,
  output logic [BWPREC-1:0] zz_pd,
  input  logic [BWPREC-1:0] zz_offw,
  input  logic [BWPREC-1:0] zz_offd,
  input  logic              zz_sh,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BWADDR-1:0] o_waddr,
  output logic [BWADDR-1:0] o_daddr,
  output logic              o_sh,
  output logic              o_last,
  output logic              done
);
  import bsmul_pkg::*;

  state_e              state;
  logic [BWLEN-1:0]    len_q, k;
  logic [2*BWPREC-1:0] pos;
  logic [BWADDR-1:0]   wbase_q, dbase_q, wstride_q, dstride_q;
  logic [BWADDR-1:0]   k_ext;
  logic                first_sh;
  logic                accept, load, k_last, pos_last, degenerate;

  always_comb begin
    start_ready = (state == IDLE);
    accept      = start && start_ready;
    zz_clr      = !rst_n || accept;
    load        = (state == RUN) && (!o_valid || o_ready);
    k_last      = (k == len_q - BWLEN'(1));
    pos_last    = (pos == (2*BWPREC)'(1));
    // Step is combinational so the new offsets are present for the very next load.
    zz_step     = load && k_last && !pos_last;
    degenerate  = (pw == '0) || (pd == '0) || (len == '0);
    k_ext       = {{(BWADDR-BWLEN){1'b0}}, k};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      zz_pw     <= '0;
      zz_pd     <= '0;
      len_q     <= '0;
      k         <= '0;
      pos       <= '0;
      wbase_q   <= '0;
      dbase_q   <= '0;
      wstride_q <= '0;
      dstride_q <= '0;
      first_sh  <= 1'b0;
      o_valid   <= 1'b0;
      o_waddr   <= '0;
      o_daddr   <= '0;
      o_sh      <= 1'b0;
      o_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            zz_pw     <= pw;
            zz_pd     <= pd;
            len_q     <= len;
            wbase_q   <= wbase;
            dbase_q   <= dbase;
            wstride_q <= wstride;
            dstride_q <= dstride;
            k         <= '0;
            pos       <= {{BWPREC{1'b0}}, pw} * {{BWPREC{1'b0}}, pd};
            first_sh  <= 1'b0;
            // Empty jobs pass through DRAIN for one cycle so done and start_ready line up.
            if (degenerate) begin
              state <= DRAIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (load) begin
            o_valid <= 1'b1;
            o_waddr <= plane_addr(wbase_q, zz_offw, wstride_q) + k_ext;
            o_daddr <= plane_addr(dbase_q, zz_offd, dstride_q) + k_ext;
            o_sh    <= (k == '0) && first_sh && zz_sh;
            o_last  <= k_last && pos_last;
            if (k_last) begin
              k   <= '0;
              pos <= pos - (2*BWPREC)'(1);
              if (pos_last) state <= DRAIN;
              else          first_sh <= 1'b1;
            end else begin
              k <= k + BWLEN'(1);
            end
          end
        end
        DRAIN: begin
          if (!o_valid || o_ready) begin
            o_valid <= 1'b0;
            o_sh    <= 1'b0;
            o_last  <= 1'b0;
            done    <= o_valid;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsmul_agu.sv
// Self-checking bench: bsmul_agu driven by a behavioural zig-zag plane walker, with
// every beat checked against a diagonal-order reference model of the whole job.
module tb_bsmul_agu;
  localparam int BWADDR = 21;
  localparam int BWLEN  = 8;
  localparam int BWPREC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              start_ready;
  logic [BWPREC-1:0] pw = '0, pd = '0;
  logic [BWLEN-1:0]  len = '0;
  logic [BWADDR-1:0] wbase = '0, dbase = '0, wstride = '0, dstride = '0;
  logic              zz_clr, zz_step;
  logic [BWPREC-1:0] zz_pw, zz_pd;
  logic [BWPREC-1:0] zz_offw = '0, zz_offd = '0;
  logic              zz_sh = 1'b0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [BWADDR-1:0] o_waddr, o_daddr;
  logic              o_sh, o_last, done;

  bsmul_agu #(.BWADDR(BWADDR), .BWLEN(BWLEN), .BWPREC(BWPREC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .pw(pw), .pd(pd), .len(len), .wbase(wbase), .dbase(dbase),
    .wstride(wstride), .dstride(dstride),
    .zz_clr(zz_clr), .zz_step(zz_step), .zz_pw(zz_pw), .zz_pd(zz_pd),
    .zz_offw(zz_offw), .zz_offd(zz_offd), .zz_sh(zz_sh),
    .o_valid(o_valid), .o_ready(o_ready), .o_waddr(o_waddr), .o_daddr(o_daddr),
    .o_sh(o_sh), .o_last(o_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BWADDR-1:0] wa;
    logic [BWADDR-1:0] da;
    logic              sh;
    logic              last;
  } beat_t;

  beat_t expa[$];
  beat_t got[$];
  int    vectors = 0;
  int    errors = 0;
  int    degen_cnt = 0;
  int    step_cnt = 0;
  bit    ready_rand = 1'b0;

  function automatic logic [63:0] mk(logic [BWADDR-1:0] wa, logic [BWADDR-1:0] da,
                                     logic sh, logic last);
    return {20'b0, wa, da, sh, last};
  endfunction

  function automatic logic [63:0] pk(beat_t b);
    return mk(b.wa, b.da, b.sh, b.last);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Zig-zag plane walker: anti-diagonals w+d ascending, w descending within a diagonal;
  // sh marks entry into a new diagonal.
  always @(posedge clk) begin
    int w, d, s, lp, nw;
    if (zz_clr) begin
      zz_offw <= '0;
      zz_offd <= '0;
      zz_sh   <= 1'b0;
    end else if (zz_step) begin
      w = int'(zz_offw);
      d = int'(zz_offd);
      if (w > 0 && d + 1 < int'(zz_pd)) begin
        zz_offw <= BWPREC'(w - 1);
        zz_offd <= BWPREC'(d + 1);
        zz_sh   <= 1'b0;
      end else begin
        s  = w + d + 1;
        lp = int'(zz_pw) - 1;
        nw = (s > lp) ? lp : s;
        zz_offw <= BWPREC'(nw);
        zz_offd <= BWPREC'(s - nw);
        zz_sh   <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    o_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && zz_step === 1'b1) step_cnt++;
  end

  task automatic push_job(input int pwv, input int pdv, input int lenv,
                          input logic [BWADDR-1:0] wb, input logic [BWADDR-1:0] ws,
                          input logic [BWADDR-1:0] db, input logic [BWADDR-1:0] ds);
    int total, cnt, wmax, wmin;
    beat_t b;
    if (pwv == 0 || pdv == 0 || lenv == 0) return;
    total = pwv * pdv * lenv;
    cnt = 0;
    for (int s = 0; s <= pwv + pdv - 2; s++) begin
      wmax = (s < pwv) ? s : pwv - 1;
      wmin = (s - pdv + 1 > 0) ? s - pdv + 1 : 0;
      for (int w = wmax; w >= wmin; w--) begin
        for (int k = 0; k < lenv; k++) begin
          b.wa   = BWADDR'(longint'(wb) + longint'(w) * longint'(ws) + longint'(k));
          b.da   = BWADDR'(longint'(db) + longint'(s - w) * longint'(ds) + longint'(k));
          b.sh   = (s > 0) && (w == wmax) && (k == 0);
          b.last = (cnt == total - 1);
          expa.push_back(b);
          cnt++;
        end
      end
    end
  endtask

  // Compare process: every handshake against the model, hold-under-stall, done timing.
  initial begin
    int    rd;
    bit    done_due, prev_stall, exp_done;
    int    degen_seen;
    beat_t held, cur;
    rd = 0; done_due = 0; prev_stall = 0; degen_seen = 0;
    forever begin
      @(negedge clk);
      cur.wa = o_waddr; cur.da = o_daddr; cur.sh = o_sh; cur.last = o_last;
      if (!rst_n) begin
        rd = expa.size();
        done_due = 0;
        prev_stall = 0;
        degen_seen = degen_cnt;
      end else begin
        if (prev_stall) chk("stall_hold", {o_valid, pk(cur)[62:0]}, {1'b1, pk(held)[62:0]});
        exp_done = done_due || (degen_cnt != degen_seen);
        degen_seen = degen_cnt;
        done_due = 0;
        chk("done", 64'(done), 64'(exp_done));
        if (o_valid && o_ready) begin
          if (rd >= expa.size()) begin
            chk("extra_beat", pk(cur), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("beat%0d", rd), pk(cur), pk(expa[rd]));
            if (expa[rd].last) done_due = 1;
            rd++;
          end
          got.push_back(cur);
        end
        prev_stall = o_valid && !o_ready;
        held = cur;
      end
    end
  end

  task automatic launch(input int pwv, input int pdv, input int lenv,
                        input logic [BWADDR-1:0] wb, input logic [BWADDR-1:0] ws,
                        input logic [BWADDR-1:0] db, input logic [BWADDR-1:0] ds,
                        input bit hold, output int base);
    int n;
    @(posedge clk); #2;
    pw = BWPREC'(pwv); pd = BWPREC'(pdv); len = BWLEN'(lenv);
    wbase = wb; wstride = ws; dbase = db; dstride = ds;
    start = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (start_ready !== 1'b1 && n < 200);
    if (start_ready !== 1'b1) chk("accept_timeout", 64'(start_ready), 64'd1);
    base = got.size();
    push_job(pwv, pdv, lenv, wb, ws, db, ds);
    @(posedge clk); #2;
    if (!hold) begin
      start = 1'b0;
      pw = BWPREC'($urandom); pd = BWPREC'($urandom); len = BWLEN'($urandom);
      wbase = BWADDR'($urandom); dbase = BWADDR'($urandom);
      wstride = BWADDR'($urandom); dstride = BWADDR'($urandom);
    end
  endtask

  task automatic finish_job(input int pwv, input int pdv, input int lenv);
    int n, budget;
    if (pwv == 0 || pdv == 0 || lenv == 0) begin
      degen_cnt++;
      @(negedge clk); #1;
      chk("degen_busy", {o_valid, start_ready, done}, {1'b0, 1'b0, 1'b1});
      @(negedge clk); #1;
      chk("degen_idle", {o_valid, start_ready, done}, {1'b0, 1'b1, 1'b0});
    end else begin
      @(negedge clk); #1;
      chk("lat_clr", 64'(o_valid), 64'd0);
      @(negedge clk); #1;
      chk("lat_first", 64'(o_valid), 64'd1);
      budget = 8 * pwv * pdv * lenv + 50;
      n = 0;
      while (done !== 1'b1 && n < budget) begin @(negedge clk); #1; n++; end
      chk("done_seen", {done, start_ready}, {1'b1, 1'b1});
    end
  endtask

  task automatic pin_job1(input string tag, input int b);
    chk({tag, "_count"}, 64'(got.size() - b), 64'd12);
    if (got.size() >= b + 12) begin
      chk({tag, "_beat0"},  pk(got[b]),      mk(21'h100, 21'h200, 1'b0, 1'b0));
      chk({tag, "_beat3"},  pk(got[b + 3]),  mk(21'h103, 21'h200, 1'b1, 1'b0));
      chk({tag, "_beat6"},  pk(got[b + 6]),  mk(21'h100, 21'h203, 1'b0, 1'b0));
      chk({tag, "_beat9"},  pk(got[b + 9]),  mk(21'h103, 21'h203, 1'b1, 1'b0));
      chk({tag, "_beat11"}, pk(got[b + 11]), mk(21'h105, 21'h205, 1'b0, 1'b1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s0, n, pwv, pdv, lenv;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {start_ready, o_valid, o_sh, o_last, done, zz_clr, zz_step},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("rst_addr", {o_waddr, o_daddr}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_clr", {zz_clr, start_ready}, {1'b0, 1'b1});

    // 2x2 planes, three words each, ready always high
    launch(2, 2, 3, 21'h100, 21'd3, 21'h200, 21'd3, 1'b0, b);
    finish_job(2, 2, 3);
    pin_job1("t1", b);

    // same job under random backpressure
    ready_rand = 1'b1;
    launch(2, 2, 3, 21'h100, 21'd3, 21'h200, 21'd3, 1'b0, b);
    finish_job(2, 2, 3);
    pin_job1("t2", b);
    ready_rand = 1'b0;

    // single data plane, one word per plane
    s0 = step_cnt;
    launch(4, 1, 1, 21'h40, 21'h10, 21'h80, 21'd5, 1'b0, b);
    finish_job(4, 1, 1);
    chk("t3_steps", 64'(step_cnt - s0), 64'd3);
    chk("t3_count", 64'(got.size() - b), 64'd4);
    if (got.size() >= b + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t3_beat%0d", i), pk(got[b + i]),
            mk(BWADDR'(32'h40 + i * 32'h10), 21'h80, (i > 0), (i == 3)));

    // empty jobs
    launch(2, 2, 0, 21'h1, 21'h1, 21'h1, 21'h1, 1'b0, b);
    finish_job(2, 2, 0);
    launch(0, 3, 2, 21'h1, 21'h1, 21'h1, 21'h1, 1'b0, b);
    finish_job(0, 3, 2);

    // asynchronous abort mid-job, then the same job from a clean start
    launch(2, 2, 3, 21'h100, 21'd3, 21'h200, 21'd3, 1'b0, b);
    n = 0;
    while (got.size() < b + 5 && n < 100) begin @(negedge clk); #1; n++; end
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {start_ready, o_valid, o_sh, o_last, done, zz_clr, zz_step},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("abort_addr", {o_waddr, o_daddr, zz_pw, zz_pd}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    launch(2, 2, 3, 21'h100, 21'd3, 21'h200, 21'd3, 1'b0, b);
    finish_job(2, 2, 3);
    pin_job1("t5", b);

    // address wrap; start held through the job, second job follows back-to-back
    launch(1, 1, 2, 21'h1FFFFF, 21'd1, 21'h10, 21'd7, 1'b1, b);
    pw = 4'd2; pd = 4'd3; len = 8'd2;
    wbase = 21'h0AAAA; wstride = 21'h1234; dbase = 21'h1F0000; dstride = 21'h8000;
    @(negedge clk); #1;
    chk("t6_busy_ignore", 64'(start_ready), 64'd0);
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    chk("t6_b2b_done", {start_ready, done}, {1'b1, 1'b1});
    push_job(2, 3, 2, 21'h0AAAA, 21'h1234, 21'h1F0000, 21'h8000);
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    while (!(done === 1'b1 && got.size() >= b + 14) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("t6_count", {done, 32'(got.size() - b)}, {1'b1, 32'd14});
    if (got.size() >= b + 2) begin
      chk("t6_wrap0", pk(got[b]),     mk(21'h1FFFFF, 21'h10, 1'b0, 1'b0));
      chk("t6_wrap1", pk(got[b + 1]), mk(21'h000000, 21'h11, 1'b0, 1'b1));
    end

    // randomized jobs under random backpressure
    ready_rand = 1'b1;
    for (int j = 0; j < 10; j++) begin
      pwv  = $urandom_range(0, 4);
      pdv  = $urandom_range(1, 4);
      lenv = $urandom_range(0, 4);
      launch(pwv, pdv, lenv, BWADDR'($urandom), BWADDR'($urandom), BWADDR'($urandom),
             BWADDR'($urandom), 1'b0, b);
      finish_job(pwv, pdv, lenv);
      chk($sformatf("rand%0d_count", j), 64'(got.size() - b), 64'(pwv * pdv * lenv));
    end
    ready_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
